// File: rtl/router_drain_sched_pkg.sv
// Shared definitions for the 1x3 router read-side drain scheduler:
// header layout, port count, FSM encoding and beat control payload.
package router_drain_sched_pkg;

  localparam int unsigned DATA_W         = 8;
  localparam int unsigned LEN_W          = 6;
  localparam int unsigned ADDR_W         = 2;
  localparam int unsigned LEN_LSB        = ADDR_W;
  localparam int unsigned NUM_PORTS      = 3;
  localparam int unsigned PORT_W         = 2;
  localparam int unsigned REM_W          = LEN_W + 1;
  localparam int unsigned CNT_W          = 5;
  localparam int unsigned LATE_LIMIT_DEF = 30;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    LEN,
    BODY
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              sop;
    logic              eop;
    logic [PORT_W-1:0] port;
  } beat_ctl_t;

  // Port index `step` positions after `base`, modulo the port count.
  function automatic logic [PORT_W-1:0] port_step(input logic [PORT_W-1:0] base,
                                                  input int unsigned step);
    return PORT_W'((32'(base) + step) % NUM_PORTS);
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin select over three requesters, starting the
// search at the port just after `last`.
module rr_pick3
  import router_drain_sched_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    last,
  output logic [PORT_W-1:0]    grant_c,
  output logic                 valid_c
);

  logic [PORT_W-1:0] cand;

  // Scan farthest-to-nearest so the nearest requester is written last and wins.
  always_comb begin
    grant_c = '0;
    valid_c = 1'b0;
    cand    = '0;
    for (int unsigned k = NUM_PORTS; k >= 1; k--) begin
      cand = port_step(last, k);
      if (req[cand]) begin
        grant_c = cand;
        valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_drain_sched.sv
// Read-side scheduler for the 1x3 router: drains whole packets round-robin
// into one byte stream, checks parity and watches for starved ports.
module router_drain_sched
  import router_drain_sched_pkg::*;
#(
  parameter int unsigned LATE_LIMIT = LATE_LIMIT_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 vld_out_0,
  input  logic                 vld_out_1,
  input  logic                 vld_out_2,
  input  logic [DATA_W-1:0]    data_out_0,
  input  logic [DATA_W-1:0]    data_out_1,
  input  logic [DATA_W-1:0]    data_out_2,
  input  logic                 sink_ready,
  output logic                 read_enb_0,
  output logic                 read_enb_1,
  output logic                 read_enb_2,
  output logic                 m_valid,
  output logic [DATA_W-1:0]    m_data,
  output logic                 m_sop,
  output logic                 m_eop,
  output logic [PORT_W-1:0]    m_port,
  output logic                 m_perr,
  output logic                 abort,
  output logic [NUM_PORTS-1:0] late_flag
);

  logic [NUM_PORTS-1:0] vld;
  state_t               state, state_nxt;
  logic [PORT_W-1:0]    grant, grant_nxt;
  logic [PORT_W-1:0]    rr_ptr, rr_ptr_nxt;
  logic [REM_W-1:0]     remaining, remaining_nxt;
  logic                 rd_c, sop_c, eop_c, abort_c;
  logic [PORT_W-1:0]    pick_grant;
  logic                 pick_valid;
  logic                 grant_vld_c;
  logic [LEN_W-1:0]     grant_len_c;
  logic [DATA_W-1:0]    beat_data_c;
  logic [DATA_W-1:0]    par_acc;
  beat_ctl_t            beat;
  logic [CNT_W-1:0]     late_cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] served_c;

  assign vld = {vld_out_2, vld_out_1, vld_out_0};

  rr_pick3 u_pick (
    .req     (vld),
    .last    (rr_ptr),
    .grant_c (pick_grant),
    .valid_c (pick_valid)
  );

  // Granted port's valid flag and header length field.
  always_comb begin
    grant_vld_c = vld_out_0;
    grant_len_c = data_out_0[DATA_W-1:LEN_LSB];
    case (grant)
      2'd1: begin
        grant_vld_c = vld_out_1;
        grant_len_c = data_out_1[DATA_W-1:LEN_LSB];
      end
      2'd2: begin
        grant_vld_c = vld_out_2;
        grant_len_c = data_out_2[DATA_W-1:LEN_LSB];
      end
      default: ;
    endcase
  end

  // Read data for the beat currently on the output stage.
  always_comb begin
    beat_data_c = data_out_0;
    case (beat.port)
      2'd1:    beat_data_c = data_out_1;
      2'd2:    beat_data_c = data_out_2;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    rr_ptr_nxt    = rr_ptr;
    remaining_nxt = remaining;
    rd_c          = 1'b0;
    sop_c         = 1'b0;
    eop_c         = 1'b0;
    abort_c       = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_nxt = pick_grant;
          state_nxt = HDR;
        end
      end
      HDR: begin
        if (sink_ready) begin
          rd_c      = 1'b1;
          sop_c     = 1'b1;
          state_nxt = LEN;
        end
      end
      LEN: begin
        // Header is on the read bus now; payload count plus the parity byte.
        remaining_nxt = REM_W'(grant_len_c) + REM_W'(1);
        state_nxt     = BODY;
      end
      BODY: begin
        if (remaining == '0) begin
          state_nxt = IDLE;
        end else if (!grant_vld_c) begin
          // FIFO emptied under us (router soft reset): drop the rest.
          abort_c    = 1'b1;
          rr_ptr_nxt = grant;
          state_nxt  = IDLE;
        end else if (sink_ready) begin
          rd_c          = 1'b1;
          remaining_nxt = remaining - REM_W'(1);
          if (remaining == REM_W'(1)) begin
            eop_c      = 1'b1;
            rr_ptr_nxt = grant;
            state_nxt  = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      rr_ptr     <= PORT_W'(NUM_PORTS - 1);
      remaining  <= '0;
      beat       <= '0;
      par_acc    <= '0;
      abort      <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      rr_ptr     <= rr_ptr_nxt;
      remaining  <= remaining_nxt;
      beat.valid <= rd_c;
      beat.sop   <= sop_c;
      beat.eop   <= eop_c;
      if (rd_c) beat.port <= grant;
      abort      <= abort_c;
      if (beat.valid) par_acc <= beat.sop ? beat_data_c : (par_acc ^ beat_data_c);
    end
  end

  assign read_enb_0 = rd_c && (grant == PORT_W'(0));
  assign read_enb_1 = rd_c && (grant == PORT_W'(1));
  assign read_enb_2 = rd_c && (grant == PORT_W'(2));
  assign m_valid    = beat.valid;
  assign m_sop      = beat.sop;
  assign m_eop      = beat.eop;
  assign m_port     = beat.port;
  assign m_data     = beat.valid ? beat_data_c : '0;
  assign m_perr     = beat.eop && ((par_acc ^ beat_data_c) != '0);

  // A port is served while it holds the grant or is the pending IDLE winner.
  always_comb begin
    served_c = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      served_c[i] = (state == IDLE) ? (pick_valid && (pick_grant == PORT_W'(i)))
                                    : (grant == PORT_W'(i));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) late_cnt[i] <= '0;
      late_flag <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (!vld[i] || served_c[i]) begin
          late_cnt[i] <= '0;
        end else begin
          if (late_cnt[i] != CNT_W'(LATE_LIMIT)) late_cnt[i] <= late_cnt[i] + CNT_W'(1);
          if (late_cnt[i] == CNT_W'(LATE_LIMIT - 1)) late_flag[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_drain_sched.sv
// Self-checking bench for router_drain_sched: three modelled router FIFOs,
// a beat scoreboard, a packet vector table and hand-written corner sequences.
module tb_router_drain_sched;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] port;
    logic       sop;
    logic       eop;
    logic       perr;
  } beat_t;

  typedef struct {
    int port;
    int len;
    bit corrupt;
    bit toggle;
    int exp_beats;
    int exp_perr;
  } vec_t;

  logic       clock      = 1'b0;
  logic       reset      = 1'b1;
  logic       sink_ready = 1'b1;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_sop, m_eop;
  logic [1:0] m_port;
  logic       m_perr;
  logic       abort;
  logic [2:0] late_flag;

  logic [7:0] mem    [3][256];
  logic [7:0] wr_ptr [3] = '{default: 8'd0};
  logic [7:0] rd_ptr [3] = '{default: 8'd0};
  logic [7:0] dout   [3] = '{default: 8'd0};
  logic [2:0] flush  = 3'b000;
  logic [2:0] rd_vec;

  beat_t exp_q[$];
  bit    sb_en  = 1'b1;
  bit    toggle = 1'b0;
  int    checks = 0;
  int    errors = 0;
  int    beats  = 0;
  int    eops   = 0;
  int    perrs  = 0;
  int    aborts = 0;
  int    viol   = 0;
  int    rd1    = 0;

  always #5 clock = ~clock;

  router_drain_sched dut (
    .clock      (clock),
    .reset      (reset),
    .vld_out_0  (vld_out_0),
    .vld_out_1  (vld_out_1),
    .vld_out_2  (vld_out_2),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2),
    .sink_ready (sink_ready),
    .read_enb_0 (read_enb_0),
    .read_enb_1 (read_enb_1),
    .read_enb_2 (read_enb_2),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_sop      (m_sop),
    .m_eop      (m_eop),
    .m_port     (m_port),
    .m_perr     (m_perr),
    .abort      (abort),
    .late_flag  (late_flag)
  );

  // Router output FIFO model: data registered on read, flush empties the FIFO.
  assign rd_vec     = {read_enb_2, read_enb_1, read_enb_0};
  assign vld_out_0  = (wr_ptr[0] != rd_ptr[0]);
  assign vld_out_1  = (wr_ptr[1] != rd_ptr[1]);
  assign vld_out_2  = (wr_ptr[2] != rd_ptr[2]);
  assign data_out_0 = dout[0];
  assign data_out_1 = dout[1];
  assign data_out_2 = dout[2];

  always @(posedge clock) begin
    for (int p = 0; p < 3; p++) begin
      if (rd_vec[p]) begin
        dout[p]   <= mem[p][rd_ptr[p]];
        rd_ptr[p] <= flush[p] ? wr_ptr[p] : rd_ptr[p] + 8'd1;
      end else if (flush[p]) begin
        rd_ptr[p] <= wr_ptr[p];
      end
    end
  end

  function automatic logic [31:0] outs();
    return {11'd0, read_enb_0, read_enb_1, read_enb_2, m_valid, m_data,
            m_sop, m_eop, m_port, m_perr, abort, late_flag};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One cycle: sample at the falling edge, score beats, then update sink_ready.
  task automatic tick();
    beat_t e, got;
    @(negedge clock);
    if (m_valid) begin
      beats++;
      if (m_eop) eops++;
      if (m_eop && m_perr) perrs++;
      if (sb_en) begin
        checks++;
        got = {m_data, m_port, m_sop, m_eop, m_perr};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got %h with nothing expected", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL beat: got data/port/sop/eop/perr %h expected %h", got, e);
          end
        end
      end
    end
    if (abort) aborts++;
    if (read_enb_1) rd1++;
    if ($countones(rd_vec) > 1) viol++;
    if ((rd_vec != 3'b000) && (!sink_ready || reset)) viol++;
    sink_ready = toggle ? ~sink_ready : 1'b1;
  endtask

  task automatic push_byte(input int p, input logic [7:0] b);
    mem[p][wr_ptr[p]] = b;
    wr_ptr[p] = wr_ptr[p] + 8'd1;
  endtask

  // Load one packet into FIFO p; the first `keep` beats go to the scoreboard.
  task automatic load_pkt(input int p, input int len, input bit corrupt, input int keep);
    logic [7:0] b, par;
    beat_t      e;
    b   = {6'(len), 2'(p)};
    par = b;
    push_byte(p, b);
    if (keep > 0) begin
      e = '{b, 2'(p), 1'b1, 1'b0, 1'b0};
      exp_q.push_back(e);
    end
    for (int i = 0; i < len; i++) begin
      b   = 8'($urandom);
      par = par ^ b;
      push_byte(p, b);
      if (i + 1 < keep) begin
        e = '{b, 2'(p), 1'b0, 1'b0, 1'b0};
        exp_q.push_back(e);
      end
    end
    b = corrupt ? (par ^ 8'h01) : par;
    push_byte(p, b);
    if (len + 1 < keep) begin
      e = '{b, 2'(p), 1'b0, 1'b1, corrupt};
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) tick();
  endtask

  initial begin
    vec_t       vecs [5];
    logic [18:0] rtr, vtr;
    int b0, e0, p0, a0, r0, n, cnt;

    vecs[0] = '{0,  0, 1'b0, 1'b0,  2, 0};
    vecs[1] = '{2, 10, 1'b0, 1'b1, 12, 0};
    vecs[2] = '{1,  5, 1'b1, 1'b0,  7, 1};
    vecs[3] = '{1,  7, 1'b0, 1'b0,  9, 0};
    vecs[4] = '{2,  3, 1'b0, 1'b1,  5, 0};

    tick();
    tick();
    chk("reset_outputs", outs(), 32'd0);
    reset = 1'b0;
    tick();
    tick();
    chk("idle_outputs", outs(), 32'd0);

    // All three ports at once: drained 0, 1, 2 from the reset pointer.
    e0 = eops;
    load_pkt(0, 3, 1'b0, 5);
    load_pkt(1, 3, 1'b0, 5);
    load_pkt(2, 3, 1'b0, 5);
    wait_drain("rr_three");
    chk("rr_three_eops", 32'(eops - e0), 32'd3);

    // Port 1, len 14: read/beat pattern cycle by cycle.
    b0 = beats;
    load_pkt(1, 14, 1'b0, 16);
    for (int i = 0; i < 19; i++) begin
      tick();
      rtr[i] = read_enb_1;
      vtr[i] = m_valid;
    end
    chk("p1_read_trace", 32'(rtr), 32'h1FFFD);
    chk("p1_beat_trace", 32'(vtr), 32'h3FFFA);
    wait_drain("p1_len14");
    chk("p1_beats", 32'(beats - b0), 32'd16);

    for (int i = 0; i < 5; i++) begin
      toggle = vecs[i].toggle;
      b0 = beats;
      e0 = eops;
      p0 = perrs;
      load_pkt(vecs[i].port, vecs[i].len, vecs[i].corrupt, vecs[i].len + 2);
      wait_drain($sformatf("vec%0d", i));
      toggle = 1'b0;
      chk($sformatf("vec%0d_beats", i), 32'(beats - b0), 32'(vecs[i].exp_beats));
      chk($sformatf("vec%0d_eops", i), 32'(eops - e0), 32'd1);
      chk($sformatf("vec%0d_perr", i), 32'(perrs - p0), 32'(vecs[i].exp_perr));
    end

    // Port 2 starved behind a len-63 packet on port 0.
    load_pkt(0, 63, 1'b0, 65);
    load_pkt(2, 3, 1'b0, 5);
    repeat (29) tick();
    chk("late_before_limit", 32'(late_flag), 32'd0);
    tick();
    chk("late_at_limit", 32'(late_flag), 32'd4);
    wait_drain("late");
    chk("late_sticky", 32'(late_flag), 32'd4);

    // Port 1 FIFO flushed after five body reads.
    a0 = aborts;
    e0 = eops;
    r0 = rd1;
    load_pkt(1, 10, 1'b0, 6);
    n   = 0;
    cnt = 0;
    while (cnt < 6 && n < 100) begin
      tick();
      if (read_enb_1) cnt++;
      n++;
    end
    chk("abort_reads_seen", 32'(cnt), 32'd6);
    flush = 3'b010;
    tick();
    flush = 3'b000;
    wait_drain("abort");
    repeat (5) tick();
    chk("abort_pulses", 32'(aborts - a0), 32'd1);
    chk("abort_no_eop", 32'(eops - e0), 32'd0);
    chk("abort_reads_total", 32'(rd1 - r0), 32'd6);
    e0 = eops;
    load_pkt(1, 2, 1'b0, 4);
    wait_drain("after_abort");
    chk("after_abort_eop", 32'(eops - e0), 32'd1);

    // Reset in the middle of a packet, then port 0 must win first.
    sb_en = 1'b0;
    load_pkt(1, 20, 1'b0, 0);
    repeat (8) tick();
    reset = 1'b1;
    #1;
    chk("reset_mid_outputs", outs(), 32'd0);
    flush = 3'b111;
    tick();
    flush = 3'b000;
    repeat (2) tick();
    chk("reset_hold_outputs", outs(), 32'd0);
    reset = 1'b0;
    sb_en = 1'b1;
    e0 = eops;
    load_pkt(0, 2, 1'b0, 4);
    load_pkt(1, 2, 1'b0, 4);
    load_pkt(2, 2, 1'b0, 4);
    wait_drain("post_reset");
    chk("post_reset_eops", 32'(eops - e0), 32'd3);

    chk("protocol_violations", 32'(viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_drain_sched.md
# router_drain_sched

Read-side scheduler for the 1x3 router. Watches the three output FIFOs' `vld_out_x` flags and drains whole packets into one downstream byte stream. Grants ports round-robin, one packet at a time, and generates `read_enb_x` from the packet header length. Checks parity and flags any port left waiting long enough to risk the router's soft-reset timeout.

## Interface
Parameters:
- `LATE_LIMIT`, 30: cycles a port may hold `vld_out_x` high unserved before its late flag sets.

Ports:
- `clock`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `vld_out_0/1/2`  in  1 each  router FIFO x non-empty.
- `data_out_0/1/2`  in  8 each  router FIFO x read data, valid the cycle after `read_enb_x`.
- `sink_ready`  in  1  high in cycle t guarantees the sink accepts a beat presented in t+1.
- `read_enb_0/1/2`  out  1 each  FIFO read strobes; at most one high per cycle.
- `m_valid`  out  1  output beat valid.
- `m_data`  out  8  output byte.
- `m_sop`  out  1  header beat.
- `m_eop`  out  1  parity beat (last).
- `m_port`  out  2  source port of the current beat.
- `m_perr`  out  1  parity mismatch, qualified by `m_eop`.
- `abort`  out  1  one-cycle pulse when a packet is dropped mid-drain.
- `late_flag`  out  3  sticky per-port late indication.

## Operation
- Packet format in the FIFO: header `{len[7:2], addr[1:0]}`, then `len` payload bytes, then one parity byte (XOR of header and payload).
- FSM states:
  - IDLE: if any `vld_out_x` is high, pick the first asserted port searching from `rr_ptr+1` (mod 3). Register it as `grant`, go to HDR.
  - HDR: when `sink_ready`, assert `read_enb[grant]`, go to LEN.
  - LEN: no read this cycle. Header beat is on `data_out[grant]`. Set `remaining = len+1`, seed parity accumulator with the header, go to BODY.
  - BODY: each cycle with `sink_ready && remaining != 0`, assert `read_enb[grant]` and decrement `remaining`. After the read with `remaining==1`, set `rr_ptr=grant` and go to IDLE.
- Output stage: a beat is emitted in t+1 for every read issued in t.
  - `m_valid` is the registered read strobe.
  - `m_data = data_out[rd_port]`; `rd_port` is the registered grant and drives `m_port`.
  - `m_sop` marks the header beat; `m_eop` marks the beat from the final BODY read.
  - `m_perr` is high on the eop beat when the accumulated XOR of all bytes including parity is nonzero.
- `len==0`: BODY issues exactly one read, the parity byte.
- Abort: if `vld_out[grant]` is low in BODY with `remaining != 0` (router soft-reset):
  - stop reading, pulse `abort`, go to IDLE, set `rr_ptr=grant`;
  - no `m_eop` is produced for that packet.
- Late watchdog, one 5-bit counter per port:
  - counts cycles while `vld_out_x` is high and the port is not the active grant (or the FSM is in IDLE with a different winner);
  - clears when the port is granted or `vld_out_x` is low;
  - at `LATE_LIMIT` sets `late_flag[x]`, which is cleared only by reset.

## Timing
- Reset values:
  - all outputs 0;
  - FSM state IDLE; `rr_ptr=2`, so port 0 has first priority;
  - counters and `remaining` 0.
- Reset mid-packet: immediate return to IDLE. No further reads or beats; any in-flight beat is discarded.
- Latency from `vld_out_x` rising in IDLE:
  - first `read_enb_x` 1 cycle later (HDR), if `sink_ready`;
  - header beat on `m_*` 2 cycles after that `vld_out_x` edge.
- Per packet: one bubble cycle (LEN). Throughput with `sink_ready` held high is `len+2` beats in `len+3` cycles, plus the IDLE cycle between packets.
- `sink_ready` low: no read issued that cycle, state held. The output stage never stalls.
- Simultaneous `vld_out` on several ports: strict round-robin at packet granularity, never mid-packet.

## Structure
- Shared router package holds:
  - header field widths and offsets (`LEN_W=6`, `ADDR_W=2`);
  - port count 3;
  - FSM state encoding {IDLE, HDR, LEN, BODY};
  - default `LATE_LIMIT`.
- One sub-module is natural: `rr_pick3`, a combinational round-robin select taking request[2:0] and last[1:0], returning grant and valid. The FSM, counters and output stage stay in the top module.

## Test plan
- Single packet on port 1, len=14, `sink_ready` held high:
  - `read_enb_1` high 1 cycle, then 15 consecutive cycles;
  - 16 beats total, `m_port=1`, `m_sop` on beat 1, `m_eop` on beat 16, `m_perr=0`.
- All three `vld_out` high at once, len=3 each: packets drain in order 0, 1, 2, with no interleaving and no read overlap.
- `sink_ready` toggling 1/0 every cycle during a len=10 packet: reads only in ready cycles, 12 beats total, data order preserved.
- Parity byte corrupted (XOR 0x01): `m_perr=1` with `m_eop`; the next packet reports `m_perr=0`.
- Port 2 held valid while port 0 streams a len=63 packet: `late_flag[2]` sets exactly `LATE_LIMIT` cycles after its `vld_out_2` rise and stays set after port 2 is drained.
- Drop `vld_out_1` after 5 body reads: `abort` pulses once, no `m_eop`, FSM returns to IDLE.
- Reset asserted mid-packet: all outputs 0 immediately; after release, port 0 wins first.
